// File: rtl/regbus_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regbus_arbiter_if : one master's request/response channel to the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
interface regbus_arbiter_if;
  logic        req;
  logic        rwn;
  logic [3:0]  addr;
  logic [3:0]  wben;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (output req, rwn, addr, wben, wdata, input ack, err, rdata);
  modport slave  (input req, rwn, addr, wben, wdata, output ack, err, rdata);
endinterface
`default_nettype wire

// File: rtl/regbus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regbus_arbiter : two-master arbiter/sequencer onto the peripheral register file
// Rev 1.0
// ---------------------------------------------------------------------------
module regbus_arbiter #(
  parameter int          FIXED_PRIO = 0,
  parameter logic [15:0] M1_WP_MASK = 16'h0000,
  parameter int          NUM_REGS   = 13
) (
  input  logic                   clk,
  input  logic                   reset_n,
  regbus_arbiter_if.slave        m0,
  regbus_arbiter_if.slave        m1,
  output logic [3:0]             rf_addr,
  output logic [3:0]             rf_wben,
  output logic                   rf_r_wn,
  output logic [31:0]            rf_wdata,
  input  logic [31:0]            rf_rdata,
  output logic                   busy
);

  localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  logic        sel;          // 0 = m0, 1 = m1
  logic        last_grant;
  logic        pend_rwn;
  logic        pend_unmapped;
  logic        pend_err;

  logic        grant_any;
  logic        grant_m1;
  logic        win_rwn;
  logic [3:0]  win_addr;
  logic [3:0]  win_wben;
  logic [31:0] win_wdata;
  logic        win_unmapped;
  logic        win_wp;
  logic        win_drop;
  logic [31:0] read_value;

  always_comb begin
    grant_any = m0.req | m1.req;
    if (FIXED_PRIO != 0)
      grant_m1 = m1.req & ~m0.req;
    else
      grant_m1 = m1.req & (~m0.req | ~last_grant);

    win_rwn   = grant_m1 ? m1.rwn   : m0.rwn;
    win_addr  = grant_m1 ? m1.addr  : m0.addr;
    win_wben  = grant_m1 ? m1.wben  : m0.wben;
    win_wdata = grant_m1 ? m1.wdata : m0.wdata;

    win_unmapped = ({1'b0, win_addr} >= NUM_REGS_W);
    win_wp       = grant_m1 & M1_WP_MASK[win_addr];
    win_drop     = ~win_rwn & (win_unmapped | win_wp);

    read_value = (pend_rwn & ~pend_unmapped) ? rf_rdata : 32'h0;
  end

  // Dropped writes are converted to reads at grant so the register file
  // never sees a write strobe for them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      sel           <= 1'b0;
      last_grant    <= 1'b1;
      pend_rwn      <= 1'b1;
      pend_unmapped <= 1'b0;
      pend_err      <= 1'b0;
      rf_addr       <= 4'h0;
      rf_wben       <= 4'h0;
      rf_r_wn       <= 1'b1;
      rf_wdata      <= 32'h0;
      busy          <= 1'b0;
      m0.ack        <= 1'b0;
      m0.err        <= 1'b0;
      m0.rdata      <= 32'h0;
      m1.ack        <= 1'b0;
      m1.err        <= 1'b0;
      m1.rdata      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            sel           <= grant_m1;
            last_grant    <= grant_m1;
            pend_rwn      <= win_rwn;
            pend_unmapped <= win_unmapped;
            pend_err      <= win_unmapped | (win_wp & ~win_rwn);
            rf_addr       <= win_addr;
            rf_wdata      <= win_wdata;
            rf_r_wn       <= win_rwn | win_drop;
            rf_wben       <= (win_rwn | win_drop) ? 4'h0 : win_wben;
            busy          <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          rf_r_wn <= 1'b1;
          rf_wben <= 4'h0;
          if (sel) begin
            m1.ack   <= 1'b1;
            m1.err   <= pend_err;
            m1.rdata <= read_value;
          end else begin
            m0.ack   <= 1'b1;
            m0.err   <= pend_err;
            m0.rdata <= read_value;
          end
          state <= RESP;
        end
        RESP: begin
          m0.ack <= 1'b0;
          m0.err <= 1'b0;
          m1.ack <= 1'b0;
          m1.err <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regbus_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regbus_arbiter : directed-vector bench for regbus_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_regbus_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  regbus_arbiter_if a0 ();
  regbus_arbiter_if a1 ();
  regbus_arbiter_if b0 ();
  regbus_arbiter_if b1 ();

  logic [3:0]  a_rf_addr, a_rf_wben, b_rf_addr, b_rf_wben;
  logic        a_rf_r_wn, b_rf_r_wn, a_busy, b_busy;
  logic [31:0] a_rf_wdata, b_rf_wdata, a_rf_rdata, b_rf_rdata;

  // Register file model: combinational read, byte-enabled write on each edge with r_wn=0
  logic [31:0] mem [16] = '{0: 32'h48524a44, 14: 32'hBAD0000E, default: 32'h0};
  assign a_rf_rdata = mem[a_rf_addr];
  assign b_rf_rdata = 32'h0;

  always @(posedge clk) begin
    if (!a_rf_r_wn)
      for (int i = 0; i < 4; i++)
        if (a_rf_wben[i]) mem[a_rf_addr][8*i +: 8] <= a_rf_wdata[8*i +: 8];
  end

  regbus_arbiter #(.FIXED_PRIO(0), .M1_WP_MASK(16'h0020), .NUM_REGS(13)) dut_a (
    .clk(clk), .reset_n(reset_n), .m0(a0), .m1(a1),
    .rf_addr(a_rf_addr), .rf_wben(a_rf_wben), .rf_r_wn(a_rf_r_wn),
    .rf_wdata(a_rf_wdata), .rf_rdata(a_rf_rdata), .busy(a_busy)
  );

  regbus_arbiter #(.FIXED_PRIO(1), .M1_WP_MASK(16'h0000), .NUM_REGS(13)) dut_b (
    .clk(clk), .reset_n(reset_n), .m0(b0), .m1(b1),
    .rf_addr(b_rf_addr), .rf_wben(b_rf_wben), .rf_r_wn(b_rf_r_wn),
    .rf_wdata(b_rf_wdata), .rf_rdata(b_rf_rdata), .busy(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  int         busy_cnt;
  logic [3:0] wben_seen;
  bit         other_ack;

  // One transaction on dut_a; optionally disturbs the payload during ACCESS
  task automatic txn(input bit mst, input bit rwn, input logic [3:0] addr,
                     input logic [3:0] wben, input logic [31:0] wdata, input bit corrupt,
                     output logic [31:0] rd, output logic er, output int lat);
    lat = -1; rd = 32'h0; er = 1'b0;
    busy_cnt = 0; wben_seen = 4'h0; other_ack = 1'b0;
    if (!mst) begin
      a0.req = 1'b1; a0.rwn = rwn; a0.addr = addr; a0.wben = wben; a0.wdata = wdata;
    end else begin
      a1.req = 1'b1; a1.rwn = rwn; a1.addr = addr; a1.wben = wben; a1.wdata = wdata;
    end
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (a_busy) busy_cnt++;
      wben_seen |= a_rf_wben;
      if (mst ? a0.ack : a1.ack) other_ack = 1'b1;
      if (i == 1 && corrupt) begin
        if (!mst) begin a0.addr = addr + 4'd1; a0.wdata = 32'h55; end
        else      begin a1.addr = addr + 4'd1; a1.wdata = 32'h55; end
      end
      if (mst ? a1.ack : a0.ack) begin
        lat = i;
        rd  = mst ? a1.rdata : a0.rdata;
        er  = mst ? a1.err : a0.err;
        break;
      end
    end
    if (!mst) a0.req = 1'b0; else a1.req = 1'b0;
    @(posedge clk); #1;
    if (a_busy) busy_cnt++;
  endtask

  task automatic do_rd(input string tag, input bit mst, input logic [3:0] addr,
                       input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d; logic e; int lat;
    txn(mst, 1'b1, addr, 4'h0, 32'h0, 1'b0, d, e, lat);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_rdata"}, d, exp_d);
    check({tag, "_err"}, {31'h0, e}, {31'h0, exp_e});
  endtask

  task automatic do_wr(input string tag, input bit mst, input logic [3:0] addr,
                       input logic [3:0] wben, input logic [31:0] wd,
                       input logic exp_e, input logic [3:0] exp_wben);
    logic [31:0] d; logic e; int lat;
    txn(mst, 1'b0, addr, wben, wd, 1'b0, d, e, lat);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_err"}, {31'h0, e}, {31'h0, exp_e});
    check({tag, "_rdata"}, d, 32'h0);
    check({tag, "_wben"}, {28'h0, wben_seen}, {28'h0, exp_wben});
    check({tag, "_oth"}, {31'h0, other_ack}, 32'h0);
  endtask

  int  seq [4];
  int  cnt;
  bit  saw;
  logic [31:0] pd; logic pe; int pl;

  initial begin
    reset_n = 1'b0;
    a0.req = 0; a0.rwn = 1; a0.addr = 0; a0.wben = 0; a0.wdata = 0;
    a1.req = 0; a1.rwn = 1; a1.addr = 0; a1.wben = 0; a1.wdata = 0;
    b0.req = 0; b0.rwn = 1; b0.addr = 0; b0.wben = 0; b0.wdata = 0;
    b1.req = 0; b1.rwn = 1; b1.addr = 0; b1.wben = 0; b1.wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {a0.ack, a1.ack, a0.err, a1.err}, 32'h0);
    check("rst_rdata0", a0.rdata, 32'h0);
    check("rst_rdata1", a1.rdata, 32'h0);
    check("rst_rf", {a_rf_r_wn, a_rf_wben, a_rf_addr, a_busy}, {23'h0, 1'b1, 8'h0, 1'b0});
    check("rst_wdata", a_rf_wdata, 32'h0);
    reset_n = 1'b1;

    // Round-robin on dut_a: first tie goes to m0
    a0.rwn = 1; a0.addr = 4'd0; a1.rwn = 1; a1.addr = 4'd1;
    a0.req = 1; a1.req = 1;
    cnt = 0;
    for (int i = 0; i < 30 && cnt < 4; i++) begin
      @(posedge clk); #1;
      if (a0.ack) begin seq[cnt] = 0; cnt++; end
      else if (a1.ack) begin seq[cnt] = 1; cnt++; end
    end
    a0.req = 0; a1.req = 0;
    check("rr_count", cnt, 4);
    check("rr_g0", seq[0], 0);
    check("rr_g1", seq[1], 1);
    check("rr_g2", seq[2], 0);
    check("rr_g3", seq[3], 1);
    check("rr_m0_rdata", a0.rdata, 32'h48524a44);
    repeat (2) @(posedge clk);

    // Fixed priority on dut_b: m0 always wins
    b0.addr = 4'd3; b0.wdata = 32'h12345678; b1.addr = 4'd3; b1.wdata = 32'h12345678;
    b0.req = 1; b1.req = 1;
    cnt = 0; saw = 0;
    for (int i = 0; i < 30 && cnt < 4; i++) begin
      @(posedge clk); #1;
      if (b1.ack) saw = 1;
      if (b0.ack) cnt++;
    end
    b0.req = 0; b1.req = 0;
    check("fp_m0_acks", cnt, 4);
    check("fp_m1_ack", {31'h0, saw}, 32'h0);
    repeat (2) @(posedge clk); #1;
    check("fp_idle", {b_rf_r_wn, b_rf_wben, b_rf_addr, b_busy, b0.err}, {21'h0, 1'b1, 4'h0, 4'h3, 1'b0, 1'b0});
    check("fp_wdata", b_rf_wdata, 32'h12345678);

    // Reset during an ACCESS write aborts it
    a0.rwn = 0; a0.addr = 4'd2; a0.wben = 4'hF; a0.wdata = 32'h11111111; a0.req = 1;
    @(posedge clk); #1;
    check("mid_wben_pre", {28'h0, a_rf_wben}, 32'hF);
    reset_n = 1'b0; #1;
    check("mid_rst_rf", {a_rf_r_wn, a_rf_wben, a_busy}, {26'h0, 1'b1, 4'h0, 1'b0});
    @(posedge clk); @(posedge clk); #1;
    a0.req = 0; reset_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a0.ack || a1.ack) saw = 1;
    end
    check("mid_no_ack", {31'h0, saw}, 32'h0);
    do_rd("post_rst_rd0", 0, 4'd0, 32'h48524a44, 1'b0);
    do_rd("post_rst_rd2", 0, 4'd2, 32'h0, 1'b0);

    // Write / readback with byte merge from m1
    do_wr("wr6_m0", 0, 4'd6, 4'hF, 32'hDEADBEEF, 1'b0, 4'hF);
    do_rd("rd6_m0", 0, 4'd6, 32'hDEADBEEF, 1'b0);
    do_wr("wr6_m1", 1, 4'd6, 4'h1, 32'h000000AA, 1'b0, 4'h1);
    do_rd("rd6_m1", 1, 4'd6, 32'hDEADBEAA, 1'b0);

    // Write protect on m1 at addr 5
    do_wr("wp_m1", 1, 4'd5, 4'hF, 32'h00001234, 1'b1, 4'h0);
    do_rd("wp_rd", 0, 4'd5, 32'h0, 1'b0);
    do_wr("wp_m0", 0, 4'd5, 4'hF, 32'h00001234, 1'b0, 4'hF);
    do_rd("wp_rd2", 0, 4'd5, 32'h00001234, 1'b0);

    // Unmapped addresses
    do_rd("um_rd14", 0, 4'd14, 32'h0, 1'b1);
    do_wr("um_wr15", 0, 4'd15, 4'hF, 32'hFFFFFFFF, 1'b1, 4'h0);
    do_rd("um_rd12", 0, 4'd12, 32'h0, 1'b0);

    // Payload disturbed during ACCESS must not reach the register file
    txn(0, 1'b0, 4'd3, 4'hF, 32'hCAFEF00D, 1'b1, pd, pe, pl);
    check("ps_lat", pl, 2);
    check("ps_busy", busy_cnt, 2);
    do_rd("ps_rd3", 0, 4'd3, 32'hCAFEF00D, 1'b0);
    do_rd("ps_rd4", 0, 4'd4, 32'h0, 1'b0);
    check("ps_busy_rd", busy_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
